iir_biquad_cascade: RTL and testbench

IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

---
 rtl/iir_biquad_cascade.sv | 175 +++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SEC direct-form-II biquads sharing one multiplier and accumulator.
// Define IIR_SAT_EN to clamp section results and enable the sticky sat flag.
module iir_biquad_cascade #(
  parameter int W = 25,
  parameter int FRAC = 20,
  parameter int N_SEC = 2,
  localparam int NC = 6 * N_SEC,
  localparam int AW = $clog2(NC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [W-1:0]  coef_wdata,
  input  logic          clr_state,
  output logic          busy,
  output logic          sat
);

  localparam int AC = 2 * W + 2;
  localparam int SW = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam logic signed [AC-1:0] HALF = AC'(1) << (FRAC - 1);
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_MW0, S_MW1, S_MW2, S_STW,
    S_MY0, S_MY1, S_MY2, S_STY, S_OUT
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0]       sec;
  logic                last_sec;
  logic                accept;
  logic signed [W-1:0] coef [NC];
  logic signed [W-1:0] w1 [N_SEC];
  logic signed [W-1:0] w2 [N_SEC];
  logic signed [W-1:0] x_r, w_r;
  logic signed [AC-1:0] acc;

  logic [2:0]           k;
  logic [AW-1:0]        cidx;
  logic signed [W-1:0]  coef_op, opd;
  logic signed [AC-1:0] prod, rsh;
  logic signed [W-1:0]  res;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid & in_ready;
  assign last_sec = (sec == SW'(N_SEC - 1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next-state sequencing through the per-section MAC steps
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_MW0;
      S_MW0:   state_nx = S_MW1;
      S_MW1:   state_nx = S_MW2;
      S_MW2:   state_nx = S_STW;
      S_STW:   state_nx = S_MY0;
      S_MY0:   state_nx = S_MY1;
      S_MY1:   state_nx = S_MY2;
      S_MY2:   state_nx = S_STY;
      S_STY:   state_nx = last_sec ? S_OUT : S_MW0;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // coefficient / data operand pair for the shared multiplier
  always_comb begin
    k   = 3'd0;
    opd = x_r;
    unique case (state)
      S_MW1:   begin k = 3'd1; opd = w1[sec]; end
      S_MW2:   begin k = 3'd2; opd = w2[sec]; end
      S_MY0:   begin k = 3'd3; opd = w_r;     end
      S_MY1:   begin k = 3'd4; opd = w1[sec]; end
      S_MY2:   begin k = 3'd5; opd = w2[sec]; end
      default: begin k = 3'd0; opd = x_r;     end
    endcase
  end

  assign cidx    = AW'(6 * int'(sec) + int'(k));
  assign coef_op = coef[cidx];
  assign prod    = coef_op * opd;
  assign rsh     = (acc + HALF) >>> FRAC;

`ifdef IIR_SAT_EN
  logic ovf;
  assign ovf = !(&rsh[AC-1:W-1]) && (|rsh[AC-1:W-1]);
  assign res = ovf ? (rsh[AC-1] ? SMIN : SMAX) : W'(rsh);

  // sticky overflow flag, set by any clamped store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat <= 1'b0;
    else if ((state == S_STW || state == S_STY) && ovf) sat <= 1'b1;
  end
`else
  assign res = W'(rsh);
  assign sat = 1'b0;
`endif

  // MAC accumulation, section stores and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      x_r       <= '0;
      w_r       <= '0;
      sec       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          x_r <= in_data;
          acc <= '0;
          sec <= '0;
        end
        S_MW0, S_MW1, S_MW2,
        S_MY0, S_MY1, S_MY2: acc <= acc + prod;
        S_STW: begin
          w_r <= res;
          acc <= '0;
        end
        S_STY: begin
          x_r <= res;
          acc <= '0;
          if (!last_sec) sec <= sec + 1'b1;
        end
        S_OUT: begin
          out_valid <= 1'b1;
          out_data  <= x_r;
        end
        default: ;
      endcase
    end
  end

  // coefficient writes and delay-line clear in IDLE, shift at section end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int i = 0; i < N_SEC; i++) begin
        w1[i] <= '0;
        w2[i] <= '0;
      end
    end else if (state == S_IDLE) begin
      if (coef_we && ({1'b0, coef_addr} < (AW+1)'(NC)))
        coef[coef_addr] <= coef_wdata;
      if (clr_state)
        for (int i = 0; i < N_SEC; i++) begin
          w1[i] <= '0;
          w2[i] <= '0;
        end
    end else if (state == S_STY) begin
      w2[sec] <= w1[sec];
      w1[sec] <= w_r;
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Randomised and directed checks of iir_biquad_cascade
// against a plain-arithmetic biquad cascade model.
module tb_iir_biquad_cascade;

  localparam int W = 25;
  localparam int FRAC = 20;
  localparam int N_SEC = 2;
  localparam int NC = 6 * N_SEC;
  localparam int AW = $clog2(NC);
  localparam int LAT = 8 * N_SEC + 1;
  localparam longint MASK = (64'sd1 <<< W) - 1;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));
  localparam longint HALF = 64'sd1 <<< (FRAC - 1);
  localparam longint ONE = 64'sd1 <<< FRAC;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data, out_data;
  logic          out_valid;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_wdata;
  logic          clr_state, busy, sat;

  int n_chk = 0;
  int n_pass = 0;

  longint mc [NC];
  longint mw1 [N_SEC];
  longint mw2 [N_SEC];
  longint msat;

  iir_biquad_cascade #(.W(W), .FRAC(FRAC), .N_SEC(N_SEC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .clr_state(clr_state), .busy(busy), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic longint wrapw(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  function automatic longint rnd(input longint a);
    longint r;
    r = (a + HALF) >>> FRAC;
`ifdef IIR_SAT_EN
    if (r > MAXV) begin msat = 1; return MAXV; end
    if (r < MINV) begin msat = 1; return MINV; end
    return r;
`else
    return wrapw(r);
`endif
  endfunction

  function automatic longint model(input longint xin);
    longint x, w, y;
    x = wrapw(xin);
    for (int s = 0; s < N_SEC; s++) begin
      w = rnd(mc[6*s] * x + mc[6*s+1] * mw1[s] + mc[6*s+2] * mw2[s]);
      y = rnd(mc[6*s+3] * w + mc[6*s+4] * mw1[s] + mc[6*s+5] * mw2[s]);
      mw2[s] = mw1[s];
      mw1[s] = w;
      x = y;
    end
    return x;
  endfunction

  task automatic model_clr();
    for (int s = 0; s < N_SEC; s++) begin
      mw1[s] = 0;
      mw2[s] = 0;
    end
  endtask

  task automatic wcoef(input int a, input longint d);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_wdata = W'(d);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (a < NC) mc[a] = wrapw(d);
  endtask

  task automatic set_sec(input int s, input longint g, input longint a1,
                         input longint a2, input longint b0,
                         input longint b1, input longint b2);
    wcoef(6*s, g);   wcoef(6*s+1, a1); wcoef(6*s+2, a2);
    wcoef(6*s+3, b0); wcoef(6*s+4, b1); wcoef(6*s+5, b2);
  endtask

  task automatic clr();
    clr_state = 1'b1;
    @(posedge clk); #1;
    clr_state = 1'b0;
    model_clr();
  endtask

  task automatic run(input longint x, input string tag, input bit poke,
                     output longint y, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_data = W'(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr_state = 1'b0;
    lat = 0;
    y = 0;
    for (int i = 1; i <= 60; i++) begin
      if (poke) begin
        coef_we = (i < 10);
        coef_addr = '0;
        coef_wdata = '0;
        clr_state = (i < 10);
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        y = longint'(out_data);
        break;
      end
    end
    coef_we = 1'b0;
    clr_state = 1'b0;
    if (lat == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic smp(input longint x, input string tag);
    longint e, y;
    int lat;
    e = model(x) & MASK;
    run(x, tag, 1'b0, y, lat);
    chk(tag, y, e);
  endtask

  initial begin
    longint y, e, e2;
    longint ys [3];
    int lat, seen, k, cyc;
    int tt [3];

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    clr_state = 1'b0;
    for (int i = 0; i < NC; i++) mc[i] = 0;
    model_clr();
    msat = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // two half-gain pass-through sections
    set_sec(0, ONE / 2, 0, 0, ONE, 0, 0);
    set_sec(1, ONE / 2, 0, 0, ONE, 0, 0);
    e = model(64'h040000) & MASK;
    run(64'h040000, "cascade", 1'b0, y, lat);
    chk("cascade_out", y, 64'h010000);
    chk("cascade_model", y, e);
    chk("cascade_lat", lat, LAT);
    @(posedge clk); #1;
    chk("pulse_low", out_valid, 0);
    chk("out_hold", out_data, 64'h010000);

    // first-order recursion in section 0, unity section 1
    set_sec(0, ONE, ONE / 2, 0, ONE, 0, 0);
    set_sec(1, ONE, 0, 0, ONE, 0, 0);
    clr();
    begin
      longint imp [4] = '{64'h010000, 0, 0, 0};
      longint exp_r [4] = '{64'h010000, 64'h008000,
                            64'h004000, 64'h002000};
      for (int i = 0; i < 4; i++) begin
        e = model(imp[i]) & MASK;
        run(imp[i], "recur", 1'b0, y, lat);
        chk($sformatf("recur_%0d", i), y, exp_r[i]);
        chk($sformatf("recur_m%0d", i), y, e);
      end
    end

    // overflow: y = x + x1 with unity gains
    set_sec(0, ONE, 0, 0, ONE, ONE, 0);
    clr();
    smp(64'h0FFFFFF, "ovf_1");
    e = model(64'h0FFFFFF) & MASK;
    run(64'h0FFFFFF, "ovf_2", 1'b0, y, lat);
`ifdef IIR_SAT_EN
    e2 = 64'h0FFFFFF;
    chk("ovf_sat", sat, 1);
`else
    e2 = 64'h1FFFFFE;
    chk("ovf_sat", sat, 0);
`endif
    chk("ovf_2_out", y, e2);
    chk("ovf_2_model", y, e);

    // clear and accept on the same edge: sample sees zeroed state
    model_clr();
    e = model(64'h000100) & MASK;
    clr_state = 1'b1;
    run(64'h000100, "clr_acc", 1'b0, y, lat);
    chk("clr_acc", y, e);
    chk("clr_acc_val", y, 64'h000100);

    // coefficient write and clear while busy must be ignored
    e = model(64'h023456) & MASK;
    run(64'h023456, "busy_poke", 1'b1, y, lat);
    chk("busy_poke", y, e);
    smp(64'h011111, "busy_after");

    // out-of-range addresses are ignored
    for (int a = NC; a < (1 << AW); a++) wcoef(a, $urandom);
    smp(64'h001234, "addr_hi");

    // in_valid held high: one accept per 8*N_SEC+2 cycles
    in_data = W'(64'h003000);
    for (int i = 0; i < 3; i++) ys[i] = model(64'h003000) & MASK;
    in_valid = 1'b1;
    k = 0;
    cyc = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        tt[k] = cyc;
        chk($sformatf("held_%0d", k), out_data, ys[k]);
        k++;
        if (k == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("held_count", k, 3);
    chk("held_first", tt[0], LAT + 1);
    chk("held_per1", tt[1] - tt[0], LAT + 1);
    chk("held_per2", tt[2] - tt[1], LAT + 1);

    // randomised coefficients, states and samples
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        wcoef($urandom_range(0, NC - 1), longint'($urandom) & MASK);
      if ($urandom_range(0, 9) == 0) clr();
      smp(longint'($urandom) & MASK, $sformatf("rand_%0d", it));
    end

    // known nonzero output before reset test
    set_sec(0, ONE, 0, 0, ONE, 0, 0);
    set_sec(1, ONE, 0, 0, ONE, 0, 0);
    clr();
    e = model(64'h000100) & MASK;
    run(64'h000100, "pass", 1'b0, y, lat);
    chk("pass_out", y, 64'h000100);
    chk("pass_model", y, e);
    chk("pass_lat", lat, LAT);

    // reset while section 0 is in MY1
    in_data = W'(64'h012345);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sat", sat, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NC; i++) mc[i] = 0;
    model_clr();
    msat = 0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_out", seen, 0);
    chk("mid_rst_ready", in_ready, 1);
    smp(64'h004321, "zero_coef");
    set_sec(0, ONE, 0, 0, ONE, 0, 0);
    set_sec(1, ONE, 0, 0, ONE, 0, 0);
    e = model(64'h000100) & MASK;
    run(64'h000100, "fresh", 1'b0, y, lat);
    chk("fresh_out", y, 64'h000100);
    chk("fresh_model", y, e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
